vx_mem_sched: RTL and testbench
===============================

# vx_mem_sched

Credit-limited round-robin scheduler that shares one memory request/response port among `NUM_REQS` requesters (clusters or cores) at the top level.
- Arbitrates requests and appends the requester index to the tag.
- Registers the winning request for one cycle.
- Routes each response back to its requester by tag.
- Caps outstanding reads per requester so one requester cannot fill downstream MSHRs.

## Interface
- `NUM_REQS`, 4: number of requesters, ≥1.
- `DATA_WIDTH`, 512: memory data bits.
- `ADDR_WIDTH`, 32: address bits.
- `TAG_IN_WIDTH`, 8: requester-side tag bits.
- `MAX_PENDING`, 8: outstanding reads allowed per requester, ≥1.
- Derived: `IDX_W` = clog2(`NUM_REQS`); `IDX_W` = 0 when `NUM_REQS`=1. `TAG_OUT_WIDTH` = `TAG_IN_WIDTH`+`IDX_W`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid_in` in [N]: request valid per requester.
- `req_rw_in` in [N]: 1 = write.
- `req_byteen_in` in [N][DATA_WIDTH/8]: byte enables.
- `req_addr_in` in [N][ADDR_WIDTH]: address.
- `req_data_in` in [N][DATA_WIDTH]: write data.
- `req_tag_in` in [N][TAG_IN_WIDTH]: requester tag.
- `req_ready_in` out [N]: request accepted.
- `req_valid_out`, `req_rw_out`, `req_byteen_out`, `req_addr_out`, `req_data_out`: out, single-port versions of the above.
- `req_tag_out` out [TAG_OUT_WIDTH]: {tag_in, idx}, idx in the LSBs.
- `req_ready_out` in 1: memory accepts the request.
- `rsp_valid_in` in 1: memory response valid.
- `rsp_data_in` in [DATA_WIDTH]: response data.
- `rsp_tag_in` in [TAG_OUT_WIDTH]: response tag.
- `rsp_ready_in` out 1: response accepted.
- `rsp_valid_out` out [N]: response valid per requester.
- `rsp_data_out` out [N][DATA_WIDTH]: response data.
- `rsp_tag_out` out [N][TAG_IN_WIDTH]: response tag with idx stripped.
- `rsp_ready_out` in [N]: requester accepts the response.
- `busy` out 1: any read outstanding or output register occupied.

## Operation
**Eligibility**
- Requester i is eligible when `req_valid_in[i]` && (`req_rw_in[i]` || `credit[i]` < `MAX_PENDING`).
- Writes never consume credit; no write response exists.

**Arbitration**
- Round-robin from pointer `rr_ptr`. The first eligible index at or after `rr_ptr`, modulo N, wins.
- On grant to i: `rr_ptr` ← (i+1) mod N. Without a grant, `rr_ptr` holds.

**Output register**
- Single slot. A grant occurs only when the slot is empty or firing this cycle (`req_valid_out` && `req_ready_out`).
- On grant: load rw/byteen/addr/data and tag {`req_tag_in[i]`, i}. Assert `req_ready_in[i]` that cycle only.
- Output fields hold stable while `req_valid_out` && !`req_ready_out`.

**Credits**
- Per-requester counter, width clog2(`MAX_PENDING`+1).
- +1 at grant of a read. −1 on response fire to that requester.
- A simultaneous +1 and −1 on the same counter leaves it unchanged.

**Response path**
- Combinational. idx = `rsp_tag_in[IDX_W-1:0]`.
- `rsp_valid_out[idx]` = `rsp_valid_in`; all other bits 0.
- `rsp_tag_out[*]` = `rsp_tag_in` >> `IDX_W`; `rsp_data_out[*]` = `rsp_data_in`.
- `rsp_ready_in` = `rsp_ready_out[idx]`.

**Error conditions** (simulation assertions)
- idx ≥ N.
- Response to a requester whose credit = 0; the counter must not underflow.

**`busy`**
- `busy` = `req_valid_out` || (|credit).

## Timing
- Reset values:
  - `req_valid_out`=0, all other request outputs 0.
  - `req_ready_in`=0.
  - `rr_ptr`=0.
  - all credits 0.
  - `busy`=0.
- Request latency: grant at cycle T; `req_valid_out` at T+1.
- Throughput: one request per cycle with `req_ready_out` held high.
- Response latency: 0 cycles.
- `req_ready_in` depends on `req_valid_in` and `req_ready_out` the same cycle. Requesters must not derive valid from ready.
- Credit takes effect the cycle after update: a requester at `MAX_PENDING`−1 that is granted is ineligible next cycle. A response fire at T makes it eligible at T+1.
- Reset mid-operation: the in-flight register and credits clear asynchronously. Responses arriving after reset trip the credit=0 assertion; the system must quiesce memory before reset.

## Structure
- Shared package `VX_gpu_pkg`: `IDX_W`/`TAG_OUT_WIDTH` helper functions and the request struct typedef (rw, byteen, addr, data, tag).
- One sub-module: `VX_rr_arbiter` (NUM_REQS; inputs requests and enable; outputs one-hot grant and index; owns `rr_ptr`).
- Credit counters, output register and response demux stay in `vx_mem_sched`.

## Test plan
1. **Fairness.** N=4, all four valid reads, `req_ready_out`=1 constantly. Required: `req_tag_out` idx sequence 0,1,2,3,0…; one grant per cycle.
2. **Credit cap.** `MAX_PENDING`=2; requester 1 issues 3 reads, no responses. Required: two grants, then `req_ready_in[1]`=0. A response with tag idx=1 yields the third grant the following cycle.
3. **Writes exempt.** Requester 0 at credit=2 (full) issues a write. Required: granted; credit stays 2.
4. **Backpressure.** `req_ready_out`=0 for 5 cycles with requesters 2 and 3 valid. Required: output fields stable, only one grant total. On release, back-to-back grants 2 then 3.
5. **Response routing.** `rsp_tag_in`={0x5A, 2'd3}, `rsp_ready_out[3]`=0, then 1. Required: `rsp_valid_out`=4'b1000, `rsp_tag_out[3]`=0x5A, `rsp_ready_in` tracks `rsp_ready_out[3]`. `credit[3]` decrements only on the fire.
6. **Reset.** Assert reset asynchronously mid-burst. Required: `req_valid_out`, `busy` and credits 0 immediately; first grant after release goes to index 0.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// VX_gpu_pkg
//   Shared definitions for the memory scheduler slice.
//   - calc_idx_w / calc_tag_out_w: width helpers for the requester index
//     appended to outgoing tags (zero index bits when there is one requester).
//   - mem_req_t: request payload layout {rw, byteen, addr, data, tag} at the
//     default memory geometry. Blocks with other geometries build the same
//     field order from their own parameters.
package VX_gpu_pkg;

  // Default memory geometry used by mem_req_t
  localparam int MEM_DATA_WIDTH   = 512;
  localparam int MEM_ADDR_WIDTH   = 32;
  localparam int MEM_TAG_IN_WIDTH = 8;
  localparam int MEM_NUM_REQS     = 4;

  // Index bits needed to name one of num_reqs requesters
  function automatic int calc_idx_w(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 0;
  endfunction

  // Downstream tag width: requester tag plus requester index in the LSBs
  function automatic int calc_tag_out_w(input int tag_in_w, input int num_reqs);
    return tag_in_w + calc_idx_w(num_reqs);
  endfunction

  localparam int MEM_TAG_OUT_WIDTH = calc_tag_out_w(MEM_TAG_IN_WIDTH, MEM_NUM_REQS);

  typedef struct packed {
    logic                           rw;
    logic [MEM_DATA_WIDTH/8-1:0]    byteen;
    logic [MEM_ADDR_WIDTH-1:0]      addr;
    logic [MEM_DATA_WIDTH-1:0]      data;
    logic [MEM_TAG_OUT_WIDTH-1:0]   tag;
  } mem_req_t;

endpackage

// File: rtl/VX_rr_arbiter.sv
// VX_rr_arbiter
//   Round-robin arbiter. The first requesting index at or after rr_ptr
//   (modulo NUM_REQS) wins; rr_ptr then moves to one past the winner.
//   Without a grant rr_ptr holds.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   requests [N]    - candidate requesters this cycle
//   enable          - grant allowed this cycle
//   grant_onehot[N] - one-hot winner (all zero when no grant)
//   grant_index     - binary winner index
//   grant_valid     - a grant was issued this cycle
module VX_rr_arbiter
  import VX_gpu_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int IDX_W    = calc_idx_w(NUM_REQS),
  localparam int IDX_WS   = (IDX_W > 0) ? IDX_W : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [IDX_WS-1:0]   grant_index,
  output logic                grant_valid
);

  logic [IDX_WS-1:0] rr_ptr_q;
  logic [IDX_WS-1:0] rr_ptr_d;

  // Scan candidates starting at rr_ptr, wrapping at NUM_REQS (which need not
  // be a power of two, so the wrap is explicit rather than by truncation).
  always_comb begin
    int cand;
    cand         = 0;
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQS) begin
        cand = cand - NUM_REQS;
      end
      if (!grant_valid && enable && requests[cand]) begin
        grant_valid        = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_index        = IDX_WS'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (int'(grant_index) == NUM_REQS - 1) ? '0 : grant_index + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/vx_mem_sched.sv
// vx_mem_sched
//   Shares one memory request/response port among NUM_REQS requesters.
//   Requests are arbitrated round-robin, tagged with the requester index in
//   the tag LSBs, and held in a single output register. Responses are routed
//   back combinationally by that index. Each requester may have at most
//   MAX_PENDING reads outstanding; writes are never counted.
// Ports:
//   clk, reset                          - clock, asynchronous active-high reset
//   req_*_in [N]                        - per-requester request channel
//   req_ready_in [N]                    - request accepted (grant) this cycle
//   req_*_out, req_ready_out            - shared memory request channel
//   rsp_valid_in/data_in/tag_in         - memory response
//   rsp_ready_in                        - response accepted by its requester
//   rsp_valid_out/data_out/tag_out [N]  - per-requester response channel
//   rsp_ready_out [N]                   - requester accepts its response
//   busy                                - read outstanding or register full
module vx_mem_sched
  import VX_gpu_pkg::*;
#(
  parameter  int NUM_REQS      = 4,
  parameter  int DATA_WIDTH    = 512,
  parameter  int ADDR_WIDTH    = 32,
  parameter  int TAG_IN_WIDTH  = 8,
  parameter  int MAX_PENDING   = 8,
  localparam int IDX_W         = calc_idx_w(NUM_REQS),
  localparam int TAG_OUT_WIDTH = calc_tag_out_w(TAG_IN_WIDTH, NUM_REQS),
  localparam int BYTEEN_W      = DATA_WIDTH / 8
) (
  input  logic                                   clk,
  input  logic                                   reset,

  input  logic [NUM_REQS-1:0]                    req_valid_in,
  input  logic [NUM_REQS-1:0]                    req_rw_in,
  input  logic [NUM_REQS-1:0][BYTEEN_W-1:0]      req_byteen_in,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]    req_addr_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]    req_data_in,
  input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]  req_tag_in,
  output logic [NUM_REQS-1:0]                    req_ready_in,

  output logic                                   req_valid_out,
  output logic                                   req_rw_out,
  output logic [BYTEEN_W-1:0]                    req_byteen_out,
  output logic [ADDR_WIDTH-1:0]                  req_addr_out,
  output logic [DATA_WIDTH-1:0]                  req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]               req_tag_out,
  input  logic                                   req_ready_out,

  input  logic                                   rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]                  rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]               rsp_tag_in,
  output logic                                   rsp_ready_in,

  output logic [NUM_REQS-1:0]                    rsp_valid_out,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]    rsp_data_out,
  output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]  rsp_tag_out,
  input  logic [NUM_REQS-1:0]                    rsp_ready_out,

  output logic                                   busy
);

  localparam int IDX_WS   = (IDX_W > 0) ? IDX_W : 1;
  localparam int CREDIT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_PENDING);

  // Same field order as VX_gpu_pkg::mem_req_t, sized by this instance
  typedef struct packed {
    logic                     rw;
    logic [BYTEEN_W-1:0]      byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } req_slot_t;

  req_slot_t                          slot_q, slot_d;
  logic                               slot_valid_q, slot_valid_d;
  logic [NUM_REQS-1:0][CREDIT_W-1:0]  credit_q, credit_d;

  logic [NUM_REQS-1:0]                eligible;
  logic                               slot_fire;
  logic                               can_load;
  logic [NUM_REQS-1:0]                grant;
  logic [IDX_WS-1:0]                  grant_idx;
  logic                               grant_valid;
  logic [TAG_OUT_WIDTH-1:0]           grant_tag;

  logic [IDX_WS-1:0]                  rsp_idx;
  logic [TAG_IN_WIDTH-1:0]            rsp_tag_stripped;
  logic [NUM_REQS-1:0]                rsp_hit;
  logic                               rsp_in_range;
  logic                               rsp_fire;
  logic                               rsp_credit_empty;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------

  // A read needs a free credit; a write never does. Credits are the
  // registered values, so a grant or response only changes eligibility
  // from the following cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid_in[i] && (req_rw_in[i] || (credit_q[i] < CREDIT_MAX));
    end
  end

  assign slot_fire = slot_valid_q && req_ready_out;
  // The slot can take a new request when empty or draining this cycle.
  // Gating with reset keeps req_ready_in low while reset is held.
  assign can_load  = !reset && (!slot_valid_q || req_ready_out);

  VX_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arbiter (
    .clk          (clk),
    .reset        (reset),
    .requests     (eligible),
    .enable       (can_load),
    .grant_onehot (grant),
    .grant_index  (grant_idx),
    .grant_valid  (grant_valid)
  );

  assign req_ready_in = grant;

  generate
    if (IDX_W > 0) begin : g_tag_idx
      assign grant_tag = {req_tag_in[grant_idx], grant_idx};
    end else begin : g_tag_noidx
      assign grant_tag = req_tag_in[0];
    end
  endgenerate

  // Output register: fields only change on a load, so they hold while
  // stalled by req_ready_out.
  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    if (slot_fire) begin
      slot_valid_d = 1'b0;
    end
    if (grant_valid) begin
      slot_valid_d  = 1'b1;
      slot_d.rw     = req_rw_in[grant_idx];
      slot_d.byteen = req_byteen_in[grant_idx];
      slot_d.addr   = req_addr_in[grant_idx];
      slot_d.data   = req_data_in[grant_idx];
      slot_d.tag    = grant_tag;
    end
  end

  assign req_valid_out  = slot_valid_q;
  assign req_rw_out     = slot_q.rw;
  assign req_byteen_out = slot_q.byteen;
  assign req_addr_out   = slot_q.addr;
  assign req_data_out   = slot_q.data;
  assign req_tag_out    = slot_q.tag;

  // ---------------------------------------------------------------------------
  // Response side (purely combinational)
  // ---------------------------------------------------------------------------

  generate
    if (IDX_W > 0) begin : g_rsp_idx
      assign rsp_idx          = rsp_tag_in[IDX_W-1:0];
      assign rsp_tag_stripped = rsp_tag_in[TAG_OUT_WIDTH-1:IDX_W];
    end else begin : g_rsp_noidx
      assign rsp_idx          = '0;
      assign rsp_tag_stripped = rsp_tag_in;
    end
  endgenerate

  // An out-of-range index matches no requester, so it is never accepted.
  always_comb begin
    rsp_hit          = '0;
    rsp_credit_empty = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_hit[i] = (int'(rsp_idx) == i);
      if (rsp_hit[i] && (credit_q[i] == '0)) begin
        rsp_credit_empty = 1'b1;
      end
    end
  end

  assign rsp_in_range  = (int'(rsp_idx) < NUM_REQS);
  assign rsp_valid_out = rsp_hit & {NUM_REQS{rsp_valid_in}};
  assign rsp_ready_in  = |(rsp_hit & rsp_ready_out);
  assign rsp_fire      = rsp_valid_in && rsp_ready_in;

  always_comb begin
    rsp_data_out = '0;
    rsp_tag_out  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_data_out[i] = rsp_data_in;
      rsp_tag_out[i]  = rsp_tag_stripped;
    end
  end

  // ---------------------------------------------------------------------------
  // Credits: +1 on a read grant, -1 on a response fire. Both in the same
  // cycle cancel. The decrement is suppressed at zero so a stray response
  // cannot wrap the counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic inc;
    logic dec;
    inc      = 1'b0;
    dec      = 1'b0;
    credit_d = credit_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      inc = grant[i] && !req_rw_in[i];
      dec = rsp_fire && rsp_hit[i] && (credit_q[i] != '0);
      if (inc && !dec) begin
        credit_d[i] = credit_q[i] + 1'b1;
      end else if (dec && !inc) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end
    end
  end

  assign busy = slot_valid_q || (|credit_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      credit_q     <= '0;
    end else begin
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      credit_q     <= credit_d;
    end
  end

  // Memory must only return tags this block issued, and only for reads
  // still outstanding.
  a_rsp_idx_range : assert property (@(posedge clk) disable iff (reset)
    rsp_valid_in |-> rsp_in_range);

  a_rsp_credit : assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> !rsp_credit_empty);

endmodule

// File: tb/tb_vx_mem_sched.sv
module tb_vx_mem_sched;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int TW  = 8;
  localparam int MP  = 2;
  localparam int BW  = DW / 8;
  localparam int TOW = TW + 2;

  logic clk = 1'b0;
  logic reset;

  logic [N-1:0]          req_valid_in;
  logic [N-1:0]          req_rw_in;
  logic [N-1:0][BW-1:0]  req_byteen_in;
  logic [N-1:0][AW-1:0]  req_addr_in;
  logic [N-1:0][DW-1:0]  req_data_in;
  logic [N-1:0][TW-1:0]  req_tag_in;
  logic [N-1:0]          req_ready_in;
  logic                  req_valid_out;
  logic                  req_rw_out;
  logic [BW-1:0]         req_byteen_out;
  logic [AW-1:0]         req_addr_out;
  logic [DW-1:0]         req_data_out;
  logic [TOW-1:0]        req_tag_out;
  logic                  req_ready_out;
  logic                  rsp_valid_in;
  logic [DW-1:0]         rsp_data_in;
  logic [TOW-1:0]        rsp_tag_in;
  logic                  rsp_ready_in;
  logic [N-1:0]          rsp_valid_out;
  logic [N-1:0][DW-1:0]  rsp_data_out;
  logic [N-1:0][TW-1:0]  rsp_tag_out;
  logic [N-1:0]          rsp_ready_out;
  logic                  busy;

  vx_mem_sched #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
    .req_addr_out(req_addr_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
    .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
    .rsp_ready_out(rsp_ready_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           rw;
    logic [BW-1:0]  byteen;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [TOW-1:0] tag;
  } exp_req_t;

  exp_req_t     sb_q[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           remaining [N];
  logic [N-1:0] granted;

  // Scoreboard: every grant pushes the payload the requester presented;
  // every fire on the memory port pops and compares.
  always @(negedge clk) begin
    exp_req_t exp_r;
    exp_req_t act_r;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (req_valid_out && req_ready_out) begin
        act_r = {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out};
        total_cnt++;
        if (sb_q.size() == 0) begin
          $display("[TB] FAIL sb_unexpected: got %h required no request", act_r);
        end else begin
          exp_r = sb_q.pop_front();
          if (act_r !== exp_r) $display("[TB] FAIL sb_payload: got %h required %h", act_r, exp_r);
          else pass_cnt++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready_in[i]) begin
          exp_r = {req_rw_in[i], req_byteen_in[i], req_addr_in[i], req_data_in[i], req_tag_in[i], 2'(i)};
          sb_q.push_back(exp_r);
        end
      end
    end
  end

  task automatic refresh(input int i);
    req_addr_in[i]   = $urandom;
    req_data_in[i]   = {$urandom, $urandom};
    req_byteen_in[i] = BW'($urandom);
    req_tag_in[i]    = TW'($urandom);
  endtask

  task automatic set_req(input int i, input int cnt, input logic rw);
    remaining[i]    = cnt;
    req_rw_in[i]    = rw;
    refresh(i);
    req_valid_in[i] = (cnt > 0);
  endtask

  task automatic sample();
    @(negedge clk);
    granted = req_ready_in;
  endtask

  // Requesters present a new payload after each acceptance
  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        if (remaining[i] > 0) remaining[i]--;
        refresh(i);
        req_valid_in[i] = (remaining[i] > 0);
      end
    end
    granted = '0;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  function automatic int pending_reqs();
    int s = 0;
    for (int i = 0; i < N; i++) s += remaining[i];
    return s;
  endfunction

  task automatic run_until_idle(input int max_cyc);
    int cyc = 0;
    while ((pending_reqs() != 0 || req_valid_out) && cyc < max_cyc) begin
      step();
      cyc++;
    end
    if (cyc >= max_cyc) begin
      total_cnt++;
      $display("[TB] FAIL idle_timeout: got %0d requests left required 0", pending_reqs());
    end
  endtask

  task automatic send_rsp(input int idx);
    int cyc = 0;
    bit done = 1'b0;
    rsp_valid_in = 1'b1;
    rsp_tag_in   = {TW'($urandom), 2'(idx)};
    rsp_data_in  = {$urandom, $urandom};
    while (!done && cyc < 20) begin
      sample();
      done = rsp_ready_in;
      advance();
      cyc++;
    end
    rsp_valid_in = 1'b0;
    if (!done) begin
      total_cnt++;
      $display("[TB] FAIL rsp_timeout idx=%0d: got no accept required accept", idx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid_in = '1;
    @(negedge clk);
    total_cnt++; if (req_ready_in !== 4'b0000) $display("[TB] FAIL reset_ready: got %b required 0000", req_ready_in); else pass_cnt++;
    total_cnt++; if (req_valid_out !== 1'b0) $display("[TB] FAIL reset_valid: got %b required 0", req_valid_out); else pass_cnt++;
    total_cnt++; if (req_addr_out !== '0 || req_tag_out !== '0) $display("[TB] FAIL reset_fields: got %h/%h required 0/0", req_addr_out, req_tag_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
    req_valid_in = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    for (int i = 0; i < N; i++) set_req(i, 2, 1'b0);
    for (int k = 0; k < 9; k++) begin
      sample();
      exp_g = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      total_cnt++; if (granted !== exp_g) $display("[TB] FAIL fair_grant k=%0d: got %b required %b", k, granted, exp_g); else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if (req_valid_out !== 1'b1 || req_tag_out[1:0] !== 2'((k - 1) % 4))
          $display("[TB] FAIL fair_order k=%0d: got valid %b idx %0d required valid 1 idx %0d", k, req_valid_out, req_tag_out[1:0], (k - 1) % 4);
        else pass_cnt++;
      end
      advance();
    end
    sample();
    total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL fair_busy: got %b required 1", busy); else pass_cnt++;
    advance();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) send_rsp(i);
    sample();
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL fair_drain: got %b required 0", busy); else pass_cnt++;
    advance();
  endtask

  task automatic test_credit_cap();
    set_req(1, 3, 1'b0);
    for (int k = 0; k < 2; k++) begin
      sample();
      total_cnt++; if (granted !== 4'b0010) $display("[TB] FAIL cap_grant k=%0d: got %b required 0010", k, granted); else pass_cnt++;
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      sample();
      total_cnt++; if (granted[1] !== 1'b0) $display("[TB] FAIL cap_blocked k=%0d: got %b required 0", k, granted[1]); else pass_cnt++;
      advance();
    end
    rsp_valid_in = 1'b1;
    rsp_tag_in   = {8'h33, 2'd1};
    rsp_data_in  = 64'h1111_2222_3333_4444;
    sample();
    total_cnt++; if (rsp_ready_in !== 1'b1) $display("[TB] FAIL cap_rsp_ready: got %b required 1", rsp_ready_in); else pass_cnt++;
    total_cnt++; if (granted[1] !== 1'b0) $display("[TB] FAIL cap_same_cycle: got %b required 0", granted[1]); else pass_cnt++;
    advance();
    rsp_valid_in = 1'b0;
    sample();
    total_cnt++; if (granted !== 4'b0010) $display("[TB] FAIL cap_regrant: got %b required 0010", granted); else pass_cnt++;
    advance();
  endtask

  task automatic test_write_exempt();
    set_req(0, 2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      sample();
      total_cnt++; if (granted !== 4'b0001) $display("[TB] FAIL wr_fill k=%0d: got %b required 0001", k, granted); else pass_cnt++;
      advance();
    end
    set_req(0, 1, 1'b0);
    sample();
    total_cnt++; if (granted[0] !== 1'b0) $display("[TB] FAIL wr_read_blocked: got %b required 0", granted[0]); else pass_cnt++;
    advance();
    set_req(0, 1, 1'b1);
    sample();
    total_cnt++; if (granted !== 4'b0001) $display("[TB] FAIL wr_granted: got %b required 0001", granted); else pass_cnt++;
    advance();
    set_req(0, 1, 1'b0);
    sample();
    total_cnt++; if (granted[0] !== 1'b0) $display("[TB] FAIL wr_credit_held: got %b required 0", granted[0]); else pass_cnt++;
    advance();
    rsp_valid_in = 1'b1;
    rsp_tag_in   = {8'h44, 2'd0};
    rsp_data_in  = 64'h5555_6666_7777_8888;
    step();
    rsp_valid_in = 1'b0;
    sample();
    total_cnt++; if (granted !== 4'b0001) $display("[TB] FAIL wr_after_rsp: got %b required 0001", granted); else pass_cnt++;
    advance();
    run_until_idle(10);
    send_rsp(0); send_rsp(0); send_rsp(1); send_rsp(1);
    sample();
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL wr_drain: got %b required 0", busy); else pass_cnt++;
    advance();
  endtask

  task automatic test_backpressure();
    logic [AW-1:0]  exp_addr;
    logic [DW-1:0]  exp_data;
    logic [TOW-1:0] exp_tag;
    req_ready_out = 1'b0;
    set_req(2, 1, 1'b0);
    set_req(3, 1, 1'b0);
    sample();
    total_cnt++; if (granted !== 4'b0100) $display("[TB] FAIL bp_first_grant: got %b required 0100", granted); else pass_cnt++;
    exp_addr = req_addr_in[2];
    exp_data = req_data_in[2];
    exp_tag  = {req_tag_in[2], 2'd2};
    advance();
    for (int k = 0; k < 4; k++) begin
      sample();
      total_cnt++; if (granted !== 4'b0000) $display("[TB] FAIL bp_no_grant k=%0d: got %b required 0000", k, granted); else pass_cnt++;
      total_cnt++;
      if (req_valid_out !== 1'b1 || req_addr_out !== exp_addr || req_data_out !== exp_data || req_tag_out !== exp_tag)
        $display("[TB] FAIL bp_hold k=%0d: got %b %h %h %h required 1 %h %h %h", k, req_valid_out, req_addr_out, req_data_out, req_tag_out, exp_addr, exp_data, exp_tag);
      else pass_cnt++;
      advance();
    end
    req_ready_out = 1'b1;
    sample();
    total_cnt++; if (granted !== 4'b1000) $display("[TB] FAIL bp_release_grant: got %b required 1000", granted); else pass_cnt++;
    total_cnt++; if (req_tag_out !== exp_tag) $display("[TB] FAIL bp_out_first: got %h required %h", req_tag_out, exp_tag); else pass_cnt++;
    advance();
    sample();
    total_cnt++; if (req_valid_out !== 1'b1 || req_tag_out[1:0] !== 2'd3) $display("[TB] FAIL bp_out_second: got %b idx %0d required 1 idx 3", req_valid_out, req_tag_out[1:0]); else pass_cnt++;
    advance();
    send_rsp(2);
    send_rsp(3);
  endtask

  task automatic test_rsp_routing();
    set_req(3, 1, 1'b0);
    run_until_idle(10);
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = {8'h5A, 2'd3};
    rsp_data_in   = 64'hDEAD_BEEF_0123_4567;
    rsp_ready_out = 4'b0111;
    sample();
    total_cnt++; if (rsp_valid_out !== 4'b1000) $display("[TB] FAIL rt_valid: got %b required 1000", rsp_valid_out); else pass_cnt++;
    total_cnt++; if (rsp_tag_out[3] !== 8'h5A) $display("[TB] FAIL rt_tag: got %h required 5a", rsp_tag_out[3]); else pass_cnt++;
    total_cnt++; if (rsp_data_out[3] !== 64'hDEAD_BEEF_0123_4567) $display("[TB] FAIL rt_data: got %h required deadbeef01234567", rsp_data_out[3]); else pass_cnt++;
    total_cnt++; if (rsp_ready_in !== 1'b0) $display("[TB] FAIL rt_ready_low: got %b required 0", rsp_ready_in); else pass_cnt++;
    advance();
    sample();
    total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL rt_no_fire_busy: got %b required 1", busy); else pass_cnt++;
    advance();
    rsp_ready_out = 4'b1111;
    sample();
    total_cnt++; if (rsp_ready_in !== 1'b1) $display("[TB] FAIL rt_ready_high: got %b required 1", rsp_ready_in); else pass_cnt++;
    advance();
    rsp_valid_in = 1'b0;
    sample();
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rt_fire_busy: got %b required 0", busy); else pass_cnt++;
    total_cnt++; if (rsp_valid_out !== 4'b0000) $display("[TB] FAIL rt_idle: got %b required 0000", rsp_valid_out); else pass_cnt++;
    advance();
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < N; i++) set_req(i, 2, 1'b0);
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    total_cnt++; if (req_valid_out !== 1'b0) $display("[TB] FAIL rst_valid: got %b required 0", req_valid_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b required 0", busy); else pass_cnt++;
    total_cnt++; if (req_ready_in !== 4'b0000) $display("[TB] FAIL rst_ready: got %b required 0000", req_ready_in); else pass_cnt++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_req(i, 1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sample();
    total_cnt++; if (granted !== 4'b0001) $display("[TB] FAIL rst_first_grant: got %b required 0001", granted); else pass_cnt++;
    advance();
    run_until_idle(20);
    for (int i = 0; i < N; i++) send_rsp(i);
    sample();
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst_final_busy: got %b required 0", busy); else pass_cnt++;
    advance();
  endtask

  initial begin
    reset         = 1'b1;
    req_valid_in  = '0;
    req_rw_in     = '0;
    req_byteen_in = '0;
    req_addr_in   = '0;
    req_data_in   = '0;
    req_tag_in    = '0;
    req_ready_out = 1'b1;
    rsp_valid_in  = 1'b0;
    rsp_data_in   = '0;
    rsp_tag_in    = '0;
    rsp_ready_out = '1;
    granted       = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;

    test_reset();
    test_fairness();
    test_credit_cap();
    test_write_exempt();
    test_backpressure();
    test_rsp_routing();
    test_reset_midburst();

    total_cnt++;
    if (sb_q.size() != 0) $display("[TB] FAIL sb_leftover: got %0d entries required 0", sb_q.size());
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
